// File: rtl/spike_rate_encoder_if.sv
// Handshake bundle for the spike rate encoder: serial intensity load,
// run start, and the spike-vector stream toward the LIF neuron array.
interface spike_rate_encoder_if #(
  parameter int N_STAGE = 2,
  parameter int VALUE_W = 8,
  parameter int STEPS_W = 8
);
  localparam int CH = 2 ** N_STAGE;

  logic               load_valid;
  logic [VALUE_W-1:0] load_data;
  logic               load_ready;
  logic               start;
  logic [STEPS_W-1:0] num_steps;
  logic [CH-1:0]      x_out;
  logic               x_valid;
  logic               x_ready;
  logic               busy;
  logic               done;

  // Controller / test side: drives loads, start and consumer ready.
  modport master (
    output load_valid, load_data, start, num_steps, x_ready,
    input  load_ready, x_out, x_valid, busy, done
  );

  // Encoder side.
  modport slave (
    input  load_valid, load_data, start, num_steps, x_ready,
    output load_ready, x_out, x_valid, busy, done
  );
endinterface

// File: rtl/spike_rate_encoder.sv
// Sigma-delta rate encoder: each channel adds its intensity into an
// accumulator every timestep and emits the carry as its spike bit.
//
// state | meaning
// IDLE  | accepting intensity loads, waiting for start
// RUN   | streaming num_steps spike vectors over x_valid/x_ready
module spike_rate_encoder #(
  parameter int N_STAGE = 2,
  parameter int VALUE_W = 8,
  parameter int STEPS_W = 8
) (
  input logic                clk,
  input logic                reset,
  spike_rate_encoder_if.slave bus
);
  localparam int CH = 2 ** N_STAGE;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_next;

  logic [VALUE_W-1:0] intensity [CH];
  logic [VALUE_W-1:0] acc       [CH];
  logic [VALUE_W:0]   sum       [CH];
  logic [CH-1:0]      carry;
  logic [N_STAGE-1:0] ptr;
  logic [STEPS_W-1:0] steps_lat;
  logic [STEPS_W-1:0] step_cnt;
  logic [CH-1:0]      x_out_q;
  logic               x_valid_q;
  logic               done_q;

  logic load_fire, start_go, start_zero, xfer, last_xfer, produce;
  logic load_ready_c, busy_c;

  // Handshake qualifiers; last_xfer compares the post-transfer count to the latched length.
  always_comb begin
    load_fire  = bus.load_valid & load_ready_c;
    start_go   = (state == IDLE) & bus.start;
    start_zero = start_go & (bus.num_steps == '0);
    xfer       = x_valid_q & bus.x_ready;
    last_xfer  = xfer & (({1'b0, step_cnt} + (STEPS_W+1)'(1)) == {1'b0, steps_lat});
    // First edge in RUN has no vector yet; afterwards produce on every non-final transfer.
    produce    = (state == RUN) & (~x_valid_q | (xfer & ~last_xfer));
  end

  // Per-channel accumulate; the carry out is the spike.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      sum[i]   = {1'b0, acc[i]} + {1'b0, intensity[i]};
      carry[i] = sum[i][VALUE_W];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next   = state;
    load_ready_c = 1'b0;
    busy_c       = 1'b0;
    case (state)
      IDLE: begin
        load_ready_c = 1'b1;
        if (bus.start && (bus.num_steps != '0)) state_next = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_xfer) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: intensity loads, run setup, vector production and completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        intensity[i] <= '0;
        acc[i]       <= '0;
      end
      ptr       <= '0;
      steps_lat <= '0;
      step_cnt  <= '0;
      x_out_q   <= '0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= start_zero | last_xfer;
      if (load_fire) begin
        intensity[ptr] <= bus.load_data;
        ptr            <= ptr + 1'b1;
      end
      // A start in the same cycle as a load still returns the pointer to channel 0.
      if (start_go) begin
        steps_lat <= bus.num_steps;
        step_cnt  <= '0;
        ptr       <= '0;
        for (int i = 0; i < CH; i++) acc[i] <= '0;
      end
      if (xfer) step_cnt <= step_cnt + 1'b1;
      if (produce) begin
        for (int i = 0; i < CH; i++) acc[i] <= sum[i][VALUE_W-1:0];
        x_out_q   <= carry;
        x_valid_q <= 1'b1;
      end else if (last_xfer) begin
        x_out_q   <= '0;
        x_valid_q <= 1'b0;
      end
    end
  end

  assign bus.load_ready = load_ready_c;
  assign bus.busy       = busy_c;
  assign bus.x_out      = x_out_q;
  assign bus.x_valid    = x_valid_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder with hand-computed spike vectors.
module tb_spike_rate_encoder;
  logic clk;
  logic reset;
  int total = 0;
  int bad   = 0;

  spike_rate_encoder_if #(.N_STAGE(2), .VALUE_W(8), .STEPS_W(8)) bus ();

  spike_rate_encoder #(.N_STAGE(2), .VALUE_W(8), .STEPS_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Results of the last collected run.
  logic [3:0] got [16];
  int got_n, ndone, first_valid, last_xfer, done_cyc, unstable, busy_seen;
  logic poke_lr;

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_data  = v;
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  // Starts a run and records the accepted vectors. stall=1 makes x_ready 1,0,0 repeating.
  // poke=1 attempts a load of 255 and a start while the run is in progress.
  task automatic run_collect(input logic [7:0] n, input bit stall, input bit poke);
    logic rdy;
    logic prev_stall;
    logic [3:0] prev_x;
    got_n = 0; ndone = 0; first_valid = -1; last_xfer = -1; done_cyc = -1;
    unstable = 0; busy_seen = 0; poke_lr = 1'b1;
    prev_stall = 1'b0; prev_x = '0;
    for (int i = 0; i < 16; i++) got[i] = 'x;
    @(negedge clk);
    bus.num_steps = n;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc < 80; cyc++) begin
      if (bus.done) begin ndone++; done_cyc = cyc; end
      if (bus.busy) busy_seen++;
      if (bus.x_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (prev_stall && (bus.x_out !== prev_x)) unstable++;
      end
      if (poke && cyc == 3) begin
        poke_lr        = bus.load_ready;
        bus.load_valid = 1'b1;
        bus.load_data  = 8'd255;
        bus.start      = 1'b1;
        bus.num_steps  = 8'd2;
      end else if (poke && cyc == 4) begin
        bus.load_valid = 1'b0;
        bus.start      = 1'b0;
      end
      rdy = stall ? ((cyc % 3) == 1) : 1'b1;
      bus.x_ready = rdy;
      if (bus.x_valid && rdy) begin
        if (got_n < 16) got[got_n] = bus.x_out;
        got_n++;
        last_xfer = cyc;
      end
      prev_stall = bus.x_valid && !rdy;
      prev_x     = bus.x_out;
      if (ndone > 0 && cyc > done_cyc + 1) break;
      @(negedge clk);
    end
    bus.x_ready = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (bus.x_valid !== 1'b0) begin bad++; $display("FAIL rst_x_valid: got %b want 0", bus.x_valid); end
    total++; if (bus.x_out !== 4'h0) begin bad++; $display("FAIL rst_x_out: got %h want 0", bus.x_out); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.load_ready !== 1'b1) begin bad++; $display("FAIL rst_load_ready: got %b want 1", bus.load_ready); end
  endtask

  task automatic test_basic();
    logic [3:0] exp_v [8];
    exp_v = '{4'h0, 4'hC, 4'h8, 4'hE, 4'h8, 4'hC, 4'h8, 4'hE};
    load(8'd0); load(8'd64); load(8'd128); load(8'd255);
    run_collect(8'd8, 1'b0, 1'b0);
    total++; if (first_valid !== 2) begin bad++; $display("FAIL basic_first_valid: got %0d want 2", first_valid); end
    total++; if (got_n !== 8) begin bad++; $display("FAIL basic_count: got %0d want 8", got_n); end
    total++; if (last_xfer - first_valid !== 7) begin bad++; $display("FAIL basic_consecutive: got span %0d want 7", last_xfer - first_valid); end
    for (int i = 0; i < 8; i++) begin
      total++; if (got[i] !== exp_v[i]) begin bad++; $display("FAIL basic_vec%0d: got %h want %h", i + 1, got[i], exp_v[i]); end
    end
    total++; if (ndone !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", ndone); end
    total++; if (done_cyc !== last_xfer + 1) begin bad++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, last_xfer + 1); end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_v [8];
    exp_v = '{4'h0, 4'hC, 4'h8, 4'hE, 4'h8, 4'hC, 4'h8, 4'hE};
    run_collect(8'd8, 1'b1, 1'b0);
    total++; if (got_n !== 8) begin bad++; $display("FAIL bp_count: got %0d want 8", got_n); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
    for (int i = 0; i < 8; i++) begin
      total++; if (got[i] !== exp_v[i]) begin bad++; $display("FAIL bp_vec%0d: got %h want %h", i + 1, got[i], exp_v[i]); end
    end
    total++; if (ndone !== 1) begin bad++; $display("FAIL bp_done_count: got %0d want 1", ndone); end
    total++; if (done_cyc !== last_xfer + 1) begin bad++; $display("FAIL bp_done_cycle: got %0d want %0d", done_cyc, last_xfer + 1); end
  endtask

  task automatic test_zero_steps();
    run_collect(8'd0, 1'b0, 1'b0);
    total++; if (done_cyc !== 1) begin bad++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
    total++; if (ndone !== 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", ndone); end
    total++; if (first_valid !== -1) begin bad++; $display("FAIL zero_x_valid: got first valid at %0d want never", first_valid); end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL zero_busy: got %0d busy cycles want 0", busy_seen); end
  endtask

  // Intensities after the wrap are {50,20,30,40}: only ch0 reaches a carry within 6 steps, at step 6.
  task automatic test_load_wrap();
    logic [3:0] exp_v [6];
    exp_v = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    load(8'd10); load(8'd20); load(8'd30); load(8'd40); load(8'd50);
    run_collect(8'd6, 1'b0, 1'b1);
    total++; if (poke_lr !== 1'b0) begin bad++; $display("FAIL run_load_ready: got %b want 0", poke_lr); end
    total++; if (got_n !== 6) begin bad++; $display("FAIL wrap_count: got %0d want 6", got_n); end
    total++; if (ndone !== 1) begin bad++; $display("FAIL wrap_done_count: got %0d want 1", ndone); end
    for (int i = 0; i < 6; i++) begin
      total++; if (got[i] !== exp_v[i]) begin bad++; $display("FAIL wrap_vec%0d: got %h want %h", i + 1, got[i], exp_v[i]); end
    end
    run_collect(8'd6, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      total++; if (got[i] !== exp_v[i]) begin bad++; $display("FAIL persist_vec%0d: got %h want %h", i + 1, got[i], exp_v[i]); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.num_steps = 8'd8;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ares_pre_busy: got %b want 1", bus.busy); end
    #3 reset = 1'b1;
    #1;
    total++; if (bus.x_valid !== 1'b0) begin bad++; $display("FAIL ares_x_valid: got %b want 0", bus.x_valid); end
    total++; if (bus.x_out !== 4'h0) begin bad++; $display("FAIL ares_x_out: got %h want 0", bus.x_out); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ares_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL ares_done: got %b want 0", bus.done); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.load_ready !== 1'b1) begin bad++; $display("FAIL ares_load_ready: got %b want 1", bus.load_ready); end
    run_collect(8'd6, 1'b0, 1'b0);
    total++; if (got_n !== 6) begin bad++; $display("FAIL ares_count: got %0d want 6", got_n); end
    for (int i = 0; i < 6; i++) begin
      total++; if (got[i] !== 4'h0) begin bad++; $display("FAIL ares_vec%0d: got %h want 0", i + 1, got[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_v [3];
    exp_v = '{4'h0, 4'hF, 4'h0};
    load(8'd128); load(8'd128); load(8'd128); load(8'd128);
    for (int r = 0; r < 2; r++) begin
      run_collect(8'd3, 1'b0, 1'b0);
      total++; if (got_n !== 3) begin bad++; $display("FAIL b2b_run%0d_count: got %0d want 3", r, got_n); end
      for (int i = 0; i < 3; i++) begin
        total++; if (got[i] !== exp_v[i]) begin bad++; $display("FAIL b2b_run%0d_vec%0d: got %h want %h", r, i + 1, got[i], exp_v[i]); end
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.start      = 1'b0;
    bus.num_steps  = '0;
    bus.x_ready    = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_steps();
    test_load_wrap();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
